// File: rtl/lcd_status_reader_pkg.sv
// Shared definitions for the LCD status/data read path.
// Holds the FSM state encodings, the default LCD read-cycle timing
// (in 50 MHz clocks), the RS codes and small state-decode helpers.
package lcd_status_reader_pkg;

  // Default timing, in clk cycles at 50 MHz.
  localparam int LCD_TAS       = 2;   // RS/RW stable to E rising
  localparam int LCD_PW_EH     = 12;  // E high width per nibble
  localparam int LCD_TCYCE_LOW = 38;  // E low time after each nibble

  localparam logic LCD_RS_STATUS = 1'b0;
  localparam logic LCD_RS_DATA   = 1'b1;

  typedef logic [3:0] lcdState_t;

  localparam lcdState_t ST_IDLE    = 4'd0;
  localparam lcdState_t ST_RELEASE = 4'd1;
  localparam lcdState_t ST_SETUP   = 4'd2;
  localparam lcdState_t ST_EHI_H   = 4'd3;
  localparam lcdState_t ST_ELO_H   = 4'd4;
  localparam lcdState_t ST_EHI_L   = 4'd5;
  localparam lcdState_t ST_ELO_L   = 4'd6;
  localparam lcdState_t ST_RESTORE = 4'd7;
  localparam lcdState_t ST_DONE    = 4'd8;

  // E is only ever high while a nibble strobe is in progress.
  function automatic logic isEHigh(input lcdState_t s);
    return (s == ST_EHI_H) || (s == ST_EHI_L);
  endfunction

  // The LCD may drive SF_DATA only while RW=1: SETUP through ELO_L.
  function automatic logic isReadActive(input lcdState_t s);
    return (s == ST_SETUP) || (s == ST_EHI_H) || (s == ST_ELO_H) ||
           (s == ST_EHI_L) || (s == ST_ELO_L);
  endfunction

  // RS is held from SETUP through RESTORE so it never changes under RW=1.
  function automatic logic isRsWindow(input lcdState_t s);
    return isReadActive(s) || (s == ST_RESTORE);
  endfunction

  // FPGA drivers stay off one cycle either side of the RW=1 window.
  function automatic logic isBusOwned(input lcdState_t s);
    return (s == ST_RELEASE) || isRsWindow(s);
  endfunction

endpackage

// File: rtl/lcd_status_reader_if.sv
// Request/response and LCD pad signals of the status reader.
//   iReq, iRS       : read request and register select (from MiniAlu side)
//   iLCD_DATA[3:0]  : SF_DATA[3:0] from the pad input buffer
//   oLCD_E/RS/RW    : LCD control pins
//   oBusRelease     : 1 = tristate the FPGA drivers on SF_DATA
//   oBusy, oValid, oData[7:0]  : transaction status and result byte
//   oBusyFlag, oAddress[6:0]   : fields of the last status read
// slave  : the reader itself.
// master : the requester / pad side.
interface lcd_status_reader_if;
  logic       iReq;
  logic       iRS;
  logic [3:0] iLCD_DATA;
  logic       oLCD_E;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic       oBusRelease;
  logic       oBusy;
  logic       oValid;
  logic [7:0] oData;
  logic       oBusyFlag;
  logic [6:0] oAddress;

  modport slave (
    input  iReq, iRS, iLCD_DATA,
    output oLCD_E, oLCD_RS, oLCD_RW, oBusRelease,
    output oBusy, oValid, oData, oBusyFlag, oAddress
  );

  modport master (
    output iReq, iRS, iLCD_DATA,
    input  oLCD_E, oLCD_RS, oLCD_RW, oBusRelease,
    input  oBusy, oValid, oData, oBusyFlag, oAddress
  );
endinterface

// File: rtl/lcd_status_reader_phase_timer.sv
// Phase timer for the LCD read FSM: loadable down-counter that stops at 0.
//   Clock, Reset : system clock, asynchronous active-high reset
//   iLoad        : load iLoadValue (takes priority over counting)
//   iEnable      : decrement while non-zero
//   iLoadValue   : phase length minus one
//   oZero        : counter is at 0 (last cycle of the current phase)
module lcd_phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iLoad,
  input  logic             iEnable,
  input  logic [CNT_W-1:0] iLoadValue,
  output logic             oZero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (iLoad) begin
      count <= iLoadValue;
    end else if (iEnable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign oZero = (count == '0);

endmodule

// File: rtl/lcd_status_reader.sv
// LCD read controller for the Spartan-3E 4-bit character LCD bus.
// Runs one HD44780 read cycle (two nibble strobes, RW=1) to fetch either
// the busy flag + address counter (RS=0) or one RAM byte (RS=1), and hands
// the assembled byte back through a req/valid handshake.
//   Clock, Reset : 50 MHz system clock, asynchronous active-high reset
//   bus          : lcd_status_reader_if.slave (request, LCD pins, result)
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for iReq; bus not owned
// RELEASE  | FPGA drivers off, RW still 0 (1 cycle)
// SETUP    | RW=1, RS valid, E low (SETUP_CYCLES)
// EHI_H    | E high, high nibble sampled on last cycle (E_HIGH_CYCLES)
// ELO_H    | E low after high nibble (E_LOW_CYCLES)
// EHI_L    | E high, low nibble sampled on last cycle (E_HIGH_CYCLES)
// ELO_L    | E low after low nibble (E_LOW_CYCLES)
// RESTORE  | RW back to 0, drivers still off (1 cycle)
// DONE     | bus returned, oValid pulse, result registers updated (1 cycle)
module lcd_status_reader
  import lcd_status_reader_pkg::*;
#(
  parameter int SETUP_CYCLES  = LCD_TAS,
  parameter int E_HIGH_CYCLES = LCD_PW_EH,
  parameter int E_LOW_CYCLES  = LCD_TCYCE_LOW,
  parameter int CNT_W         = 6
) (
  input  logic Clock,
  input  logic Reset,
  lcd_status_reader_if.slave bus
);

  localparam int MAX_PHASE =
    (SETUP_CYCLES > E_HIGH_CYCLES)
      ? ((SETUP_CYCLES > E_LOW_CYCLES) ? SETUP_CYCLES : E_LOW_CYCLES)
      : ((E_HIGH_CYCLES > E_LOW_CYCLES) ? E_HIGH_CYCLES : E_LOW_CYCLES);

  if ((SETUP_CYCLES < 1) || (E_HIGH_CYCLES < 1) || (E_LOW_CYCLES < 1)) begin : gBadPhase
    $error("lcd_status_reader: phase lengths must be at least 1 cycle");
  end
  if ((CNT_W < 1) || ((MAX_PHASE - 1) >= (1 << CNT_W))) begin : gBadCntW
    $error("lcd_status_reader: CNT_W too narrow for the longest phase");
  end

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_EHIGH = CNT_W'(E_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_ELOW  = CNT_W'(E_LOW_CYCLES - 1);

  lcdState_t        state;
  lcdState_t        nextState;
  logic             timerZero;
  logic             timerLoad;
  logic [CNT_W-1:0] timerLoadValue;
  logic             rsLatched;
  logic [3:0]       hiNib;
  logic [3:0]       loNib;

  // Single-cycle states (RELEASE, RESTORE, DONE, IDLE) load 0.
  function automatic logic [CNT_W-1:0] phaseLoad(input lcdState_t s);
    case (s)
      ST_SETUP:            return LD_SETUP;
      ST_EHI_H, ST_EHI_L:  return LD_EHIGH;
      ST_ELO_H, ST_ELO_L:  return LD_ELOW;
      default:             return '0;
    endcase
  endfunction

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:    if (bus.iReq) nextState = ST_RELEASE;
      ST_RELEASE: if (timerZero) nextState = ST_SETUP;
      ST_SETUP:   if (timerZero) nextState = ST_EHI_H;
      ST_EHI_H:   if (timerZero) nextState = ST_ELO_H;
      ST_ELO_H:   if (timerZero) nextState = ST_EHI_L;
      ST_EHI_L:   if (timerZero) nextState = ST_ELO_L;
      ST_ELO_L:   if (timerZero) nextState = ST_RESTORE;
      ST_RESTORE: if (timerZero) nextState = ST_DONE;
      ST_DONE:    nextState = ST_IDLE;
      default:    nextState = ST_IDLE;
    endcase
  end

  // Reload on every state entry so each phase starts from its full length.
  assign timerLoad      = (nextState != state);
  assign timerLoadValue = phaseLoad(nextState);

  lcd_phase_timer #(
    .CNT_W (CNT_W)
  ) uPhaseTimer (
    .Clock      (Clock),
    .Reset      (Reset),
    .iLoad      (timerLoad),
    .iEnable    (1'b1),
    .iLoadValue (timerLoadValue),
    .oZero      (timerZero)
  );

  // Pin and handshake outputs are registered from nextState so they are
  // glitch-free and change on the same edge as the state itself.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state           <= ST_IDLE;
      rsLatched       <= LCD_RS_STATUS;
      hiNib           <= '0;
      loNib           <= '0;
      bus.oLCD_E      <= 1'b0;
      bus.oLCD_RS     <= 1'b0;
      bus.oLCD_RW     <= 1'b0;
      bus.oBusRelease <= 1'b0;
      bus.oBusy       <= 1'b0;
      bus.oValid      <= 1'b0;
      bus.oData       <= '0;
      bus.oBusyFlag   <= 1'b1;  // assume busy until a status read says otherwise
      bus.oAddress    <= '0;
    end else begin
      state <= nextState;

      if ((state == ST_IDLE) && bus.iReq) begin
        rsLatched <= bus.iRS;
      end
      // Sample at the end of the last E-high cycle, after tDDR has elapsed.
      if ((state == ST_EHI_H) && timerZero) begin
        hiNib <= bus.iLCD_DATA;
      end
      if ((state == ST_EHI_L) && timerZero) begin
        loNib <= bus.iLCD_DATA;
      end

      bus.oLCD_E      <= isEHigh(nextState);
      bus.oLCD_RW     <= isReadActive(nextState);
      bus.oLCD_RS     <= isRsWindow(nextState) ? rsLatched : 1'b0;
      bus.oBusRelease <= isBusOwned(nextState);
      bus.oBusy       <= (nextState != ST_IDLE);
      bus.oValid      <= (nextState == ST_DONE);

      if ((nextState == ST_DONE) && (state != ST_DONE)) begin
        bus.oData <= {hiNib, loNib};
        if (rsLatched == LCD_RS_STATUS) begin
          bus.oBusyFlag <= hiNib[3];
          bus.oAddress  <= {hiNib[2:0], loNib};
        end
      end
    end
  end

endmodule
